spi_mem_responder: RTL and testbench
====================================

SPI_MEM_RESPONDER -- requirements
Module: spi_mem_responder

Interface
REQ-001 Parameter ADDR_W, default 24, width of the SPI address field and of mem_addr.
REQ-002 Parameter SYNC_STAGES, default 2, number of synchronizer flops on each SPI input.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 spi_sclk  input  1  SPI clock from the SoC initiator (mode 0), asynchronous to clk.
REQ-006 spi_cs_n  input  1  SPI chip select, active-low.
REQ-007 spi_mosi  input  1  serial data from the initiator.
REQ-008 spi_miso  output  1  serial data to the initiator.
REQ-009 spi_miso_oe  output  1  output enable for spi_miso, high only while read data is driven.
REQ-010 mem_addr  output  ADDR_W  byte address for the local memory port.
REQ-011 mem_re  output  1  one-cycle read strobe; mem_rdata is valid exactly one clk later.
REQ-012 mem_we  output  1  one-cycle write strobe, qualified by mem_addr and mem_wdata.
REQ-013 mem_wdata  output  8  write data byte.
REQ-014 mem_rdata  input  8  read data byte, valid one clk after mem_re.
REQ-015 busy  output  1  high whenever the state is not IDLE.

Function
REQ-016 spi_sclk, spi_cs_n and spi_mosi SHALL each pass through SYNC_STAGES flops; rise/fall events of sclk and cs_n come from the synchronized values, with mosi sampled on the same cycle as the sclk rise event.
REQ-017 The timing contract is sclk high and low phases each >= 4 clk periods, and cs_n setup/hold around sclk edges >= 4 clk periods; behaviour outside this contract is undefined.
REQ-018 The protocol is SPI mode 0: MSB first, mosi sampled on the sclk rise event, miso changed on the sclk fall event.
REQ-019 The state machine SHALL have the states IDLE, CMD, ADDR, RDATA, WDATA and IGNORE.
REQ-020 IDLE -> CMD on a cs_n fall event; the bit counter clears.
REQ-021 CMD SHALL shift 8 bits; after the 8th: 0x03 -> ADDR (read), 0x02 -> ADDR (write), any other value -> IGNORE.
REQ-022 ADDR SHALL shift ADDR_W bits into the address register; after the last bit: read -> RDATA, write -> WDATA.
REQ-023 On entering RDATA, mem_re SHALL pulse on the clk after the last address rise event, with mem_addr equal to the received address.
REQ-024 The returned byte loads into the transmit shift register one clk after the mem_re pulse; spi_miso_oe rises in that same cycle and spi_miso presents bit 7.
REQ-025 In RDATA, each sclk fall event shifts the next bit onto spi_miso.
REQ-026 On the rise event of bit 7 of each byte, the address increments and mem_re pulses for the new address; the fetched byte loads on the next fall event.
REQ-027 In WDATA, on the 8th rise event of each byte: mem_we pulses for one clk with the current mem_addr and mem_wdata equal to the byte; the address then increments.
REQ-028 The address SHALL wrap from 2^ADDR_W-1 to 0.
REQ-029 A cs_n rise event in any state SHALL force IDLE on the next clk, with spi_miso_oe=0 and the bit counter cleared.
REQ-030 On a cs_n rise event, a partial write byte is discarded with no mem_we; a mem_re already issued completes but its data is dropped.
REQ-031 IGNORE holds spi_miso_oe=0 and issues no memory strobes until the cs_n rise event.
REQ-032 mem_re and mem_we SHALL never be high in the same cycle.

Reset
REQ-033 While rst is high: state=IDLE, spi_miso=0, spi_miso_oe=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, and all synchronizers preset to the idle level (cs_n=1, sclk=0).
REQ-034 Reset asserted mid-transaction SHALL abort without strobes; after release, the block waits for a fresh cs_n fall event.

Structure
REQ-035 Package spi_mem_pkg SHALL hold the state enum, CMD_READ=8'h03, CMD_WRITE=8'h02 and the default ADDR_W.
REQ-036 Sub-module spi_sync_edge (SYNC_STAGES synchronizer plus rise/fall detect) SHALL be instantiated once per SPI input.

Verification
REQ-037 Read test: mem holds 0xA5 at 0x000100; cmd 03, addr 000100, 8 clocks -> miso shifts 10100101, one mem_re with addr 0x000100.
REQ-038 Burst read with wrap: read at 0xFFFFFF for 2 bytes -> mem_re at 0xFFFFFF, then at 0x000000.
REQ-039 Write test: cmd 02, addr 000010, bytes 11 22 -> mem_we at 0x000010/0x11, then 0x000011/0x22; spi_miso_oe stays 0.
REQ-040 Aborted write: cmd 02, addr 000010, 5 data bits, then cs_n high -> no mem_we; busy=0 within 4 clk.
REQ-041 Unknown command: cmd 0x9F plus 32 clocks -> no strobes, spi_miso_oe=0 throughout.
REQ-042 Reset pulse during RDATA -> all outputs 0 immediately; a subsequent read at 0x000100 returns correct data.

Source files
------------

// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg: shared state encoding, command opcodes and default address width
package spi_mem_pkg;
    typedef enum logic [2:0] {IDLE, CMD, ADDR, RDATA, WDATA, IGNORE} state_t;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam int ADDR_W_DEF = 24;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with rise/fall event detection
module spi_sync_edge #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync;
    logic q_d;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sync <= {STAGES{INIT}};
            q_d  <= INIT;
        end else begin
            sync <= STAGES'({sync, d});
            q_d  <= sync[STAGES-1];
        end
    assign q    = sync[STAGES-1];
    assign rise = q & ~q_d;
    assign fall = ~q & q_d;
endmodule

// File: rtl/spi_mem_responder.sv
// spi_mem_responder: SPI mode-0 target translating read/write commands onto a byte memory port
module spi_mem_responder import spi_mem_pkg::*; #(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);
    localparam int CW = $clog2(ADDR_W);
    state_t state;
    logic [CW-1:0] bit_cnt;
    logic [7:0] cmd_sr, wr_sr, tx_sr, hold, cmd_next, wr_next;
    logic is_write, rd_pending, hold_valid;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi;
    logic sclk_lvl_unused, cs_lvl_unused, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk (
        .clk(clk), .rst(rst), .d(spi_sclk), .q(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_cs (
        .clk(clk), .rst(rst), .d(spi_cs_n), .q(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall));
    spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_mosi (
        .clk(clk), .rst(rst), .d(spi_mosi), .q(mosi), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

    assign cmd_next = {cmd_sr[6:0], mosi};
    assign wr_next  = {wr_sr[6:0], mosi};
    assign busy     = state != IDLE;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            cmd_sr      <= '0;
            wr_sr       <= '0;
            tx_sr       <= '0;
            hold        <= '0;
            is_write    <= 1'b0;
            rd_pending  <= 1'b0;
            hold_valid  <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            mem_addr    <= '0;
            mem_re      <= 1'b0;
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
        end else begin
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            rd_pending <= mem_re;
            if (cs_rise) begin
                state       <= IDLE;
                bit_cnt     <= '0;
                hold_valid  <= 1'b0;
                spi_miso    <= 1'b0;
                spi_miso_oe <= 1'b0;
            end else case (state)
                IDLE: if (cs_fall) begin
                    state   <= CMD;
                    bit_cnt <= '0;
                end
                CMD: if (sclk_rise) begin
                    cmd_sr  <= cmd_next;
                    bit_cnt <= bit_cnt + CW'(1);
                    if (bit_cnt == CW'(7)) begin
                        bit_cnt  <= '0;
                        is_write <= cmd_next == CMD_WRITE;
                        state    <= (cmd_next == CMD_READ || cmd_next == CMD_WRITE) ? ADDR : IGNORE;
                    end
                end
                ADDR: if (sclk_rise) begin
                    mem_addr <= {mem_addr[ADDR_W-2:0], mosi};
                    bit_cnt  <= bit_cnt + CW'(1);
                    if (bit_cnt == CW'(ADDR_W - 1)) begin
                        bit_cnt <= '0;
                        state   <= is_write ? WDATA : RDATA;
                        mem_re  <= !is_write;
                    end
                end
                RDATA: begin
                    // First fetched byte goes straight out; prefetched ones wait for the byte boundary fall
                    if (rd_pending && !spi_miso_oe) begin
                        tx_sr       <= mem_rdata;
                        spi_miso    <= mem_rdata[7];
                        spi_miso_oe <= 1'b1;
                    end else if (rd_pending) begin
                        hold       <= mem_rdata;
                        hold_valid <= 1'b1;
                    end
                    if (sclk_rise) begin
                        bit_cnt <= (bit_cnt == CW'(7)) ? '0 : bit_cnt + CW'(1);
                        if (bit_cnt == CW'(7)) begin
                            mem_addr <= mem_addr + ADDR_W'(1);
                            mem_re   <= 1'b1;
                        end
                    end else if (sclk_fall && bit_cnt != '0) begin
                        tx_sr    <= {tx_sr[6:0], 1'b0};
                        spi_miso <= tx_sr[6];
                    end else if (sclk_fall && hold_valid) begin
                        tx_sr      <= hold;
                        spi_miso   <= hold[7];
                        hold_valid <= 1'b0;
                    end
                end
                WDATA: begin
                    if (mem_we)
                        mem_addr <= mem_addr + ADDR_W'(1);
                    if (sclk_rise) begin
                        wr_sr   <= wr_next;
                        bit_cnt <= (bit_cnt == CW'(7)) ? '0 : bit_cnt + CW'(1);
                        if (bit_cnt == CW'(7)) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= wr_next;
                        end
                    end
                end
                IGNORE: ;
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_spi_mem_responder.sv
// tb_spi_mem_responder: table-driven SPI transactions plus abort and reset sequences
module tb_spi_mem_responder;
    logic clk = 1'b0, rst = 1'b1;
    logic spi_sclk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
    logic spi_miso, spi_miso_oe, mem_re, mem_we, busy;
    logic [23:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    int total = 0, bad = 0, oe_cnt = 0, both_cnt = 0;
    logic [23:0] re_q[$];
    logic [31:0] we_q[$];

    typedef struct packed {
        logic [7:0]      cmd;
        logic [23:0]     addr;
        logic [1:0]      n;
        logic [2:0][7:0] tx;
        logic [2:0][7:0] rx;
        logic [23:0]     a0;
        logic [23:0]     a1;
    } vec_t;
    vec_t tbl[6];

    spi_mem_responder dut (
        .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .mem_addr(mem_addr), .mem_re(mem_re),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy));

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_val(input logic [23:0] a);
        return (a == 24'h000100) ? 8'hA5 : (a[7:0] ^ 8'h5A ^ (a[23] ? 8'h0F : 8'h00));
    endfunction

    always @(posedge clk)
        if (mem_re) mem_rdata <= mem_val(mem_addr);

    always @(negedge clk) begin
        if (mem_re) re_q.push_back(mem_addr);
        if (mem_we) we_q.push_back({mem_addr, mem_wdata});
        if (spi_miso_oe) oe_cnt++;
        if (mem_re && mem_we) both_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic spi_bit(input logic b, output logic s);
        spi_mosi = b;
        repeat (6) @(negedge clk);
        spi_sclk = 1'b1;
        s = spi_miso;
        repeat (6) @(negedge clk);
        spi_sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
        for (int i = 7; i >= 0; i--) spi_bit(b[i], r[i]);
    endtask

    task automatic cs_begin();
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_end();
        repeat (6) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_header(input logic [7:0] cmd, input logic [23:0] addr);
        logic [7:0] junk;
        spi_byte(cmd, junk);
        spi_byte(addr[23:16], junk);
        spi_byte(addr[15:8], junk);
        spi_byte(addr[7:0], junk);
    endtask

    task automatic run_txn(input logic [7:0] cmd, input logic [23:0] addr, input int n,
                           input logic [2:0][7:0] tx, output logic [2:0][7:0] rx);
        rx = '0;
        cs_begin();
        send_header(cmd, addr);
        for (int i = 0; i < n; i++) spi_byte(tx[i], rx[i]);
        cs_end();
    endtask

    task automatic clear_log();
        re_q.delete();
        we_q.delete();
        oe_cnt = 0;
    endtask

    initial begin
        logic [2:0][7:0] rx;
        logic s;
        int hits;
        tbl[0] = '{8'h03, 24'h000100, 2'd1, 24'h000000, 24'h0000A5, 24'h000100, 24'h000101};
        tbl[1] = '{8'h03, 24'hFFFFFF, 2'd2, 24'h000000, 24'h005AAA, 24'hFFFFFF, 24'h000000};
        tbl[2] = '{8'h02, 24'h000010, 2'd2, 24'h002211, 24'h000000, 24'h000010, 24'h000011};
        tbl[3] = '{8'h9F, 24'h123456, 2'd1, 24'h0000C3, 24'h000000, 24'h000000, 24'h000000};
        tbl[4] = '{8'h02, 24'hFFFFFF, 2'd2, 24'h0055AA, 24'h000000, 24'hFFFFFF, 24'h000000};
        tbl[5] = '{8'h03, 24'h000123, 2'd3, 24'h000000, 24'h7F7E79, 24'h000123, 24'h000124};

        repeat (4) @(negedge clk);
        check("rst_miso", 32'(spi_miso), 0);
        check("rst_oe", 32'(spi_miso_oe), 0);
        check("rst_re", 32'(mem_re), 0);
        check("rst_we", 32'(mem_we), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_wdata", 32'(mem_wdata), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            clear_log();
            run_txn(tbl[v].cmd, tbl[v].addr, int'(tbl[v].n), tbl[v].tx, rx);
            check($sformatf("v%0d_busy_idle", v), 32'(busy), 0);
            if (tbl[v].cmd == 8'h03) begin
                for (int i = 0; i < int'(tbl[v].n); i++)
                    check($sformatf("v%0d_rd_byte%0d", v, i), 32'(rx[i]), 32'(tbl[v].rx[i]));
                check($sformatf("v%0d_re_present", v), 32'(re_q.size() > 0), 1);
                if (re_q.size() > 0) check($sformatf("v%0d_re_addr0", v), 32'(re_q[0]), 32'(tbl[v].a0));
                if (tbl[v].n > 1 && re_q.size() > 1)
                    check($sformatf("v%0d_re_addr1", v), 32'(re_q[1]), 32'(tbl[v].a1));
                hits = 0;
                foreach (re_q[k]) if (re_q[k] == tbl[v].a0) hits++;
                check($sformatf("v%0d_re_once", v), 32'(hits), 1);
                check($sformatf("v%0d_rd_no_we", v), 32'(we_q.size()), 0);
            end else if (tbl[v].cmd == 8'h02) begin
                check($sformatf("v%0d_we_count", v), 32'(we_q.size()), 32'(tbl[v].n));
                for (int i = 0; i < int'(tbl[v].n) && i < we_q.size(); i++)
                    check($sformatf("v%0d_we%0d", v, i), we_q[i],
                          {(i == 0) ? tbl[v].a0 : tbl[v].a1, tbl[v].tx[i]});
                check($sformatf("v%0d_wr_oe", v), 32'(oe_cnt), 0);
                check($sformatf("v%0d_wr_no_re", v), 32'(re_q.size()), 0);
            end else begin
                check($sformatf("v%0d_ign_strobes", v), 32'(re_q.size() + we_q.size()), 0);
                check($sformatf("v%0d_ign_oe", v), 32'(oe_cnt), 0);
            end
        end

        // aborted write: 5 data bits, then chip select released
        clear_log();
        cs_begin();
        send_header(8'h02, 24'h000010);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, s);
        repeat (6) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("abort_busy", 32'(busy), 0);
        repeat (10) @(negedge clk);
        check("abort_no_we", 32'(we_q.size()), 0);
        check("abort_oe", 32'(oe_cnt), 0);

        // reset pulse in the middle of a read data phase
        clear_log();
        cs_begin();
        send_header(8'h03, 24'h000100);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, s);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_oe", 32'(spi_miso_oe), 0);
        check("mid_rst_miso", 32'(spi_miso), 0);
        check("mid_rst_addr", 32'(mem_addr), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_strobes", 32'({mem_re, mem_we}), 0);
        spi_cs_n = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_idle", 32'(busy), 0);
        clear_log();
        run_txn(8'h03, 24'h000100, 1, '0, rx);
        check("post_rst_rd", 32'(rx[0]), 32'h000000A5);
        check("post_rst_re", 32'(re_q.size() > 0 ? re_q[0] : 24'hDEAD00), 32'h00000100);
        check("re_we_excl", 32'(both_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
